// File: rtl/blit_bus_defs.sv
// Shared definitions for the blitter bus master.
// Covers state encodings, bus widths and response error codes.
package blit_bus_defs;

  localparam int ADDR_W = 27;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ADDR,
    S_STROBE,
    S_TERM
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_BERR,
    ERR_TIMEOUT,
    ERR_LANES
  } err_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              uds;
    logic              lds;
  } bus_req_t;

endpackage

// File: rtl/blit_bus_timeout.sv
// Strobe watchdog: held cleared while load is high, counts otherwise.
// Instantiated only when BLIT_BUS_MASTER_TIMEOUT_EN is defined.
module blit_bus_timeout #(
  parameter int CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  output logic expire_o
);

  localparam int W = $clog2(CYCLES + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expire_o = (cnt_q == W'(CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = '0;
    else if (!expire_o)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/blit_bus_master.sv
// Blitter memory-side bus initiator with interlocked strobe/dtack cycle.
// Optional strobe timeout: define BLIT_BUS_MASTER_TIMEOUT_EN.
module blit_bus_master
  import blit_bus_defs::*;
#(
  parameter int SETUP_CYCLES = 1
`ifdef BLIT_BUS_MASTER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_uds,
  input  logic              req_lds,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              bus_request,
  input  logic              bus_grant,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_addr_oe,
  output logic [DATA_W-1:0] bus_data_out,
  output logic              bus_data_oe,
  input  logic [DATA_W-1:0] bus_data_in,
  output logic              bus_write,
  output logic              bus_uds,
  output logic              bus_lds,
  output logic              bus_strobe,
  input  logic              bus_dtack,
  input  logic              bus_berr
);

  localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

  state_e            state_q, state_d;
  bus_req_t          req_q, req_d;
  err_e              err_q, err_d;
  err_e              code_q, code_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rsp_q, rsp_d;
  logic [SW-1:0]     setup_q, setup_d;
  logic              tmo_expire;

`ifdef BLIT_BUS_MASTER_TIMEOUT_EN
  blit_bus_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .load_i   (state_q != S_STROBE),
    .expire_o (tmo_expire)
  );
  assign rsp_timeout = rsp_q && (code_q == ERR_TIMEOUT);
`else
  assign tmo_expire  = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  assign rsp_valid    = rsp_q;
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = rsp_q && (code_q != ERR_NONE);
  assign bus_addr     = bus_addr_oe ? req_q.addr : '0;
  assign bus_data_out = bus_data_oe ? req_q.wdata : '0;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    err_d       = err_q;
    code_d      = code_q;
    rdata_d     = rdata_q;
    rsp_d       = 1'b0;
    setup_d     = setup_q;
    req_ready   = 1'b0;
    bus_request = 1'b0;
    bus_addr_oe = 1'b0;
    bus_data_oe = 1'b0;
    bus_write   = 1'b0;
    bus_strobe  = 1'b0;
    bus_uds     = 1'b0;
    bus_lds     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          req_d = '{write: req_write, addr: req_addr,
                    wdata: req_wdata, uds: req_uds,
                    lds: req_lds};
          err_d = ERR_NONE;
          // No lane enabled: answer with an error, never touch the bus
          if (!req_uds && !req_lds) begin
            rsp_d  = 1'b1;
            code_d = ERR_LANES;
          end else begin
            state_d = S_ARB;
          end
        end
      end
      S_ARB: begin
        bus_request = 1'b1;
        setup_d     = '0;
        if (bus_grant) state_d = S_ADDR;
      end
      S_ADDR: begin
        bus_request = 1'b1;
        bus_addr_oe = 1'b1;
        bus_write   = req_q.write;
        bus_data_oe = req_q.write;
        if (setup_q == SW'(SETUP_CYCLES - 1))
          state_d = S_STROBE;
        else
          setup_d = setup_q + 1'b1;
      end
      S_STROBE: begin
        bus_request = 1'b1;
        bus_addr_oe = 1'b1;
        bus_write   = req_q.write;
        bus_data_oe = req_q.write;
        bus_strobe  = 1'b1;
        bus_uds     = req_q.uds;
        bus_lds     = req_q.lds;
        if (bus_berr) begin
          err_d   = ERR_BERR;
          state_d = S_TERM;
        end else if (bus_dtack) begin
          if (!req_q.write) rdata_d = bus_data_in;
          state_d = S_TERM;
        end else if (tmo_expire) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_TERM;
        end
      end
      S_TERM: begin
        bus_request = 1'b1;
        bus_addr_oe = 1'b1;
        bus_write   = req_q.write;
        bus_data_oe = req_q.write;
        if (!bus_dtack && !bus_berr) begin
          state_d = S_IDLE;
          rsp_d   = 1'b1;
          code_d  = err_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      err_q   <= ERR_NONE;
      code_q  <= ERR_NONE;
      rdata_q <= '0;
      rsp_q   <= 1'b0;
      setup_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      err_q   <= err_d;
      code_q  <= code_d;
      rdata_q <= rdata_d;
      rsp_q   <= rsp_d;
      setup_q <= setup_d;
    end
  end

endmodule

// File: tb/tb_blit_bus_master.sv
// Directed plus randomized bench for blit_bus_master.
// Timeout scenario runs when BLIT_BUS_MASTER_TIMEOUT_EN is defined.
module tb_blit_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [26:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_uds, req_lds;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [15:0] rsp_rdata;
  logic        bus_request, bus_grant;
  logic [26:0] bus_addr;
  logic        bus_addr_oe, bus_data_oe;
  logic [15:0] bus_data_out, bus_data_in;
  logic        bus_write, bus_uds, bus_lds, bus_strobe;
  logic        bus_dtack, bus_berr;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] model_rd = 16'h0;

  always #5 clk = ~clk;

  blit_bus_master #(
    .SETUP_CYCLES (1)
`ifdef BLIT_BUS_MASTER_TIMEOUT_EN
    , .TIMEOUT_CYCLES (4)
`endif
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_uds      (req_uds),
    .req_lds      (req_lds),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .rsp_timeout  (rsp_timeout),
    .bus_request  (bus_request),
    .bus_grant    (bus_grant),
    .bus_addr     (bus_addr),
    .bus_addr_oe  (bus_addr_oe),
    .bus_data_out (bus_data_out),
    .bus_data_oe  (bus_data_oe),
    .bus_data_in  (bus_data_in),
    .bus_write    (bus_write),
    .bus_uds      (bus_uds),
    .bus_lds      (bus_lds),
    .bus_strobe   (bus_strobe),
    .bus_dtack    (bus_dtack),
    .bus_berr     (bus_berr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // bmode: 0 dtack, 1 dtack+berr together, 2 berr only
  task automatic txn(input string tag,
                     input logic wr,
                     input logic [26:0] a,
                     input logic [15:0] wd,
                     input logic u, input logic l,
                     input int g, input int dly,
                     input int hold, input int bmode,
                     input logic [15:0] din);
    int   cyc, scnt, tcnt, lat, sc, hx, exp_lat;
    bit   acked, arb_ok, stb_ok, stb_seen, lanes;
    logic e, t, exp_err, exp_to;
    logic [15:0] rd;
    lanes = u | l;
    chk({tag, ".ready"}, req_ready, 1'b1);
    req_valid   = 1'b1;
    req_write   = wr;
    req_addr    = a;
    req_wdata   = wd;
    req_uds     = u;
    req_lds     = l;
    bus_grant   = (g == 0);
    bus_data_in = din;
    bus_dtack   = 1'b0;
    bus_berr    = 1'b0;
    step();
    req_valid = 1'b0;
    cyc = 1; lat = -1; scnt = 0; tcnt = 0;
    acked = 0; arb_ok = 1; stb_ok = 1; stb_seen = 0;
    e = 1'bx; t = 1'bx; rd = 'x;
    while (cyc < 300) begin
      if (rsp_valid) begin
        lat = cyc; e = rsp_err; t = rsp_timeout; rd = rsp_rdata;
        break;
      end
      bus_grant = (cyc > g);
      if (lanes && cyc <= g + 1 &&
          (bus_addr_oe || bus_strobe || !bus_request))
        arb_ok = 0;
      if (bus_strobe) begin
        stb_seen = 1;
        if (bus_write !== wr || bus_data_oe !== wr ||
            bus_uds !== u || bus_lds !== l ||
            bus_addr !== a || !bus_addr_oe ||
            (wr && bus_data_out !== wd))
          stb_ok = 0;
        if (scnt >= dly) begin
          acked     = 1;
          bus_dtack = (bmode != 2);
          bus_berr  = (bmode != 0);
        end
        scnt++;
      end else if (acked) begin
        if (tcnt < hold) tcnt++;
        else begin
          bus_dtack = 1'b0;
          bus_berr  = 1'b0;
        end
      end
      step();
      cyc++;
    end
    sc = dly + 1;
    exp_to = 1'b0;
`ifdef BLIT_BUS_MASTER_TIMEOUT_EN
    if (sc > 4) begin
      sc = 4;
      exp_to = 1'b1;
    end
`endif
    hx = exp_to ? 0 : hold;
    exp_lat = lanes ? (g + sc + hx + 4) : 1;
    exp_err = !lanes || (bmode != 0) || exp_to;
    if (lanes && !wr && !exp_err) model_rd = din;
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".err"}, e, exp_err);
    chk({tag, ".timeout"}, t, lanes && exp_to);
    chk({tag, ".rdata"}, rd, model_rd);
    chk({tag, ".strobe"}, stb_seen && stb_ok, lanes);
    if (lanes) chk({tag, ".arb"}, arb_ok, 1'b1);
    step();
    chk({tag, ".pulse"}, rsp_valid, 1'b0);
  endtask

  initial begin
    int seen, rsps;
    reset       = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    req_uds     = 1'b0;
    req_lds     = 1'b0;
    bus_grant   = 1'b0;
    bus_data_in = '0;
    bus_dtack   = 1'b0;
    bus_berr    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.ctl",
        {req_ready, rsp_valid, rsp_err, rsp_timeout,
         bus_request, bus_addr_oe, bus_data_oe, bus_write,
         bus_uds, bus_lds, bus_strobe}, 11'b100_0000_0000);
    chk("reset.addr", bus_addr, 27'h0);
    chk("reset.data", {bus_data_out, rsp_rdata}, 32'h0);
    reset = 1'b1;
    step();

    txn("read", 1'b0, 27'h0001234, 16'h0, 1'b1, 1'b1,
        0, 0, 0, 0, 16'hBEEF);
    txn("wr_upper", 1'b1, 27'h0000ABC, 16'hA55A, 1'b1, 1'b0,
        0, 1, 0, 0, 16'h1111);
    txn("berr_dtack", 1'b0, 27'h7FFFFFF, 16'h0, 1'b1, 1'b1,
        0, 0, 3, 1, 16'h2222);
    txn("grant_wait", 1'b0, 27'h0000010, 16'h0, 1'b0, 1'b1,
        10, 0, 0, 0, 16'h3C3C);
    txn("no_lanes", 1'b1, 27'h0000020, 16'h5555, 1'b0, 1'b0,
        0, 0, 0, 0, 16'h4444);
    txn("berr_only", 1'b1, 27'h0000030, 16'h6666, 1'b0, 1'b1,
        1, 2, 1, 2, 16'h7777);
`ifdef BLIT_BUS_MASTER_TIMEOUT_EN
    txn("timeout", 1'b0, 27'h0000040, 16'h0, 1'b1, 1'b1,
        0, 100, 0, 0, 16'h8888);
`endif

    for (int i = 0; i < 12; i++) begin
      int bm;
      bm = $urandom_range(0, 3);
      if (bm == 3) bm = 0;
      txn($sformatf("rnd%0d", i), 1'($urandom),
          27'($urandom), 16'($urandom),
          1'($urandom), 1'($urandom),
          $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 2), bm, 16'($urandom));
    end

    req_valid   = 1'b1;
    req_write   = 1'b0;
    req_addr    = 27'h0000123;
    req_uds     = 1'b1;
    req_lds     = 1'b1;
    bus_grant   = 1'b1;
    bus_dtack   = 1'b0;
    bus_berr    = 1'b0;
    step();
    req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      if (bus_strobe) seen = 1;
      else step();
    end
    chk("rst_mid.reach_strobe", seen, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid.bus",
        {bus_strobe, bus_request, bus_addr_oe, bus_data_oe,
         bus_write, bus_uds, bus_lds}, 7'b0);
    chk("rst_mid.addr", bus_addr, 27'h0);
    chk("rst_mid.rsp", {req_ready, rsp_valid}, 2'b10);
    step();
    reset = 1'b1;
    rsps = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) rsps++;
      step();
    end
    chk("rst_mid.no_rsp", rsps, 0);
    chk("rst_mid.ready", req_ready, 1'b1);

    txn("post_reset", 1'b0, 27'h0000ACE, 16'h0, 1'b1, 1'b1,
        0, 0, 0, 0, 16'hCAFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
